branch_history_table: RTL and testbench

//  Fetch-stage dynamic branch predictor with a fully associative branch target buffer.

---
 rtl/bht_pkg.sv | 20 ++
 rtl/bht_sat_counter.sv | 20 ++
 rtl/branch_history_table.sv | 123 ++++++++++++
 tb/tb_branch_history_table.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared types and constants for the branch history table: BTB entry layout
// and the 2-bit saturating counter encodings.
package bht_pkg;

  // Address fields of an entry are BHT_WIDTH wide; the top's WIDTH must match.
  localparam int BHT_WIDTH = 32;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [BHT_WIDTH-1:0] tag;
    logic [BHT_WIDTH-1:0] target;
    logic [1:0]           ctr;
  } bht_entry_t;

endpackage

// File: rtl/bht_sat_counter.sv
// Next-state logic of a 2-bit up/down saturating counter (one per BTB entry);
// the counter value itself lives in the entry register of the top.
module bht_sat_counter
  import bht_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_up,
  output logic [1:0] o_next
);

  always_comb begin
    o_next = i_ctr;
    if (i_up) begin
      if (i_ctr != CTR_ST) o_next = i_ctr + 2'b01;
    end else begin
      if (i_ctr != CTR_SNT) o_next = i_ctr - 2'b01;
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// Fetch-stage branch predictor with a fully associative BTB and round-robin
// replacement. Define BHT_PERF_EN to add the hit_cnt / mis_cnt counters.
module branch_history_table
  import bht_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int WIDTH   = BHT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       pcsrc,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pcbranch,
  input  logic [WIDTH-1:0] originalpc,
  output logic [WIDTH-1:0] pcnext,
  output logic             clrbp
`ifdef BHT_PERF_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      mis_cnt
`endif
);

  localparam int IDXW = $clog2(ENTRIES);

  bht_entry_t       r_tab [ENTRIES];
  logic [IDXW-1:0]  r_ptr;
  logic [IDXW-1:0]  r_idx_q;
  logic [WIDTH-1:0] r_pc_q;
  logic [WIDTH-1:0] r_fall_q;
  logic             r_hit_q;
  logic             r_pred_q;
  logic             r_pv;

  logic [IDXW-1:0]  w_idx;
  logic             w_hit;
  logic             w_pred;
  logic             w_taken;
  logic             w_mis;
  logic [1:0]       w_ctr_next [ENTRIES];

  // CAM lookup: tags are unique, so at most one entry matches.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_tab[i].valid && (r_tab[i].tag == pc)) begin
        w_hit = 1'b1;
        w_idx = IDXW'(i);
      end
    end
    w_pred = w_hit && r_tab[w_idx].ctr[1];
  end

  // Resolution of the instruction fetched last cycle; an unknown or jump
  // pcsrc falls into the not-taken default.
  always_comb begin
    w_taken = 1'b0;
    if (r_pv && pcsrc[0] && !pcsrc[1]) w_taken = 1'b1;
    w_mis  = r_pv && (w_taken != r_pred_q);
    clrbp  = w_mis;
    pcnext = originalpc;
    if (w_mis) pcnext = w_taken ? pcbranch : r_fall_q;
    else if (w_pred) pcnext = r_tab[w_idx].target;
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    bht_sat_counter u_ctr (
      .i_ctr  (r_tab[g].ctr),
      .i_up   (w_taken),
      .o_next (w_ctr_next[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_tab[i] <= '0;
      r_ptr    <= '0;
      r_idx_q  <= '0;
      r_pc_q   <= '0;
      r_fall_q <= '0;
      r_hit_q  <= 1'b0;
      r_pred_q <= 1'b0;
      r_pv     <= 1'b0;
    end else begin
      if (r_pv) begin
        if (r_hit_q) begin
          r_tab[r_idx_q].ctr <= w_ctr_next[r_idx_q];
          if (w_taken) r_tab[r_idx_q].target <= pcbranch;
        end else if (w_taken) begin
          r_tab[r_ptr] <= '{valid: 1'b1, tag: r_pc_q, target: pcbranch, ctr: CTR_WT};
          r_ptr        <= (r_ptr == IDXW'(ENTRIES - 1)) ? '0 : r_ptr + 1'b1;
        end
      end
      // The fetch made during a flush cycle is wrong-path and never resolved.
      r_pc_q   <= pc;
      r_hit_q  <= w_hit;
      r_idx_q  <= w_idx;
      r_pred_q <= w_pred;
      r_fall_q <= originalpc;
      r_pv     <= !w_mis;
    end
  end

`ifdef BHT_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_mis_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (r_pv && r_hit_q) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_mis)           r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign hit_cnt = r_hit_cnt;
  assign mis_cnt = r_mis_cnt;
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table: directed scenarios plus
// randomized traffic against a table-level reference model.
module tb_branch_history_table;

  localparam int ENTRIES = 8;

  logic        clk;
  logic        reset;
  logic [1:0]  pcsrc;
  logic [31:0] pc;
  logic [31:0] pcbranch;
  logic [31:0] originalpc;
  logic [31:0] pcnext;
  logic        clrbp;
`ifdef BHT_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] mis_cnt;
`endif

  int n_cmp;
  int n_err;

  branch_history_table #(.ENTRIES(ENTRIES), .WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcsrc      (pcsrc),
    .pc         (pc),
    .pcbranch   (pcbranch),
    .originalpc (originalpc),
    .pcnext     (pcnext),
    .clrbp      (clrbp)
`ifdef BHT_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .mis_cnt    (mis_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic        m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_ptr;
  // instruction awaiting resolution
  logic        m_pv;
  logic [31:0] m_pc_q;
  logic [31:0] m_fall_q;
  logic        m_hit_q;
  int          m_idx_q;
  logic        m_pred_q;
  // this cycle
  logic        m_hit;
  int          m_idx;
  logic        m_pred;
  logic        m_taken;
  logic        m_mis;
  logic [31:0] exp_pcnext;
  logic        exp_clrbp;
  int          m_hit_cnt;
  int          m_mis_cnt;

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 0;
    end
    m_ptr     = 0;
    m_pv      = 1'b0;
    m_pc_q    = '0;
    m_fall_q  = '0;
    m_hit_q   = 1'b0;
    m_idx_q   = 0;
    m_pred_q  = 1'b0;
    m_hit_cnt = 0;
    m_mis_cnt = 0;
  endtask

  task automatic model_eval();
    m_hit = 1'b0;
    m_idx = 0;
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_tag[i] == pc) begin
        m_hit = 1'b1;
        m_idx = i;
      end
    m_pred  = m_hit && (m_ctr[m_idx] >= 2);
    m_taken = m_pv && (pcsrc == 2'b01);
    m_mis   = m_pv && (m_taken != m_pred_q);
    exp_clrbp = m_mis;
    if (m_mis) exp_pcnext = m_taken ? pcbranch : m_fall_q;
    else       exp_pcnext = m_pred ? m_tgt[m_idx] : originalpc;
  endtask

  task automatic model_update();
    if (m_pv) begin
      if (m_hit_q) begin
        m_hit_cnt++;
        if (m_taken) begin
          m_ctr[m_idx_q] = (m_ctr[m_idx_q] == 3) ? 3 : m_ctr[m_idx_q] + 1;
          m_tgt[m_idx_q] = pcbranch;
        end else begin
          m_ctr[m_idx_q] = (m_ctr[m_idx_q] == 0) ? 0 : m_ctr[m_idx_q] - 1;
        end
      end else if (m_taken) begin
        m_valid[m_ptr] = 1'b1;
        m_tag[m_ptr]   = m_pc_q;
        m_tgt[m_ptr]   = pcbranch;
        m_ctr[m_ptr]   = 2;
        m_ptr          = (m_ptr + 1) % ENTRIES;
      end
    end
    if (m_mis) m_mis_cnt++;
    m_pc_q   = pc;
    m_hit_q  = m_hit;
    m_idx_q  = m_idx;
    m_pred_q = m_pred;
    m_fall_q = originalpc;
    m_pv     = !m_mis;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] p, input logic [31:0] o,
                       input logic [1:0] s, input logic [31:0] b);
    @(negedge clk);
    pc         = p;
    originalpc = o;
    pcsrc      = s;
    pcbranch   = b;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_update();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; pc = 32'd1; originalpc = 32'd2; pcsrc = 2'b00; pcbranch = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (pcnext !== 32'd2 || clrbp !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: pcnext=%h clrbp=%b want 2 0", pcnext, clrbp);
    end
`ifdef BHT_PERF_EN
    n_cmp++;
    if (hit_cnt !== 32'd0 || mis_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_perf: hit=%0d mis=%0d want 0 0", hit_cnt, mis_cnt);
    end
`endif
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(32'd1, 32'd2, 2'b00, 32'd0);
      n_cmp++;
      if (pcnext !== 32'd2 || clrbp !== 1'b0) begin
        n_err++;
        $display("FAIL reset_noalloc%0d: pcnext=%h clrbp=%b want 2 0", k, pcnext, clrbp);
      end
      tick();
    end
  endtask

  task automatic test_allocate();
    drive(32'h3, 32'h4, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== 32'h4 || clrbp !== 1'b0) begin
      n_err++; $display("FAIL alloc_miss: pcnext=%h clrbp=%b want 4 0", pcnext, clrbp);
    end
    tick();
    drive(32'h4, 32'h8, 2'b01, 32'h50);
    n_cmp++;
    if (pcnext !== 32'h50 || clrbp !== 1'b1) begin
      n_err++; $display("FAIL alloc_mis: pcnext=%h clrbp=%b want 50 1", pcnext, clrbp);
    end
    tick();
    drive(32'h50, 32'h54, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== 32'h54 || clrbp !== 1'b0) begin
      n_err++; $display("FAIL alloc_flushed: pcnext=%h clrbp=%b want 54 0", pcnext, clrbp);
    end
    tick();
    drive(32'h54, 32'h58, 2'b01, 32'h10);
    n_cmp++;
    if (pcnext !== 32'h10 || clrbp !== 1'b1) begin
      n_err++; $display("FAIL alloc2_mis: pcnext=%h clrbp=%b want 10 1", pcnext, clrbp);
    end
    tick();
    drive(32'h10, 32'h14, 2'b00, 32'h0);
    tick();
    drive(32'h50, 32'h54, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== 32'h10 || clrbp !== 1'b0) begin
      n_err++; $display("FAIL alloc2_predict: pcnext=%h clrbp=%b want 10 0", pcnext, clrbp);
    end
    tick();
    drive(32'h10, 32'h14, 2'b01, 32'h10);
    n_cmp++;
    if (pcnext !== 32'h14 || clrbp !== 1'b0) begin
      n_err++; $display("FAIL alloc2_correct: pcnext=%h clrbp=%b want 14 0", pcnext, clrbp);
    end
    tick();
  endtask

  task automatic test_not_taken_mispredict();
    drive(32'h3, 32'h23, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== 32'h50 || clrbp !== 1'b0) begin
      n_err++; $display("FAIL nt_predict: pcnext=%h clrbp=%b want 50 0", pcnext, clrbp);
    end
    tick();
    drive(32'h50, 32'h54, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== 32'h23 || clrbp !== 1'b1) begin
      n_err++; $display("FAIL nt_mis: pcnext=%h clrbp=%b want 23 1", pcnext, clrbp);
    end
    tick();
    // counter now weakly not-taken: no prediction, then taken mispredict
    drive(32'h3, 32'h23, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== 32'h23 || clrbp !== 1'b0) begin
      n_err++; $display("FAIL nt_weak: pcnext=%h clrbp=%b want 23 0", pcnext, clrbp);
    end
    tick();
    drive(32'h23, 32'h27, 2'b01, 32'h50);
    n_cmp++;
    if (pcnext !== 32'h50 || clrbp !== 1'b1) begin
      n_err++; $display("FAIL nt_retrain: pcnext=%h clrbp=%b want 50 1", pcnext, clrbp);
    end
    tick();
  endtask

  task automatic test_saturate_and_replace();
    for (int i = 0; i < 4; i++) begin
      drive(32'h3, 32'h23, (i == 0) ? 2'b00 : 2'b01, 32'h10);
      n_cmp++;
      if (pcnext !== 32'h50 || clrbp !== 1'b0) begin
        n_err++; $display("FAIL sat_loop3_%0d: pcnext=%h clrbp=%b want 50 0", i, pcnext, clrbp);
      end
      tick();
      drive(32'h50, 32'h54, 2'b01, 32'h50);
      n_cmp++;
      if (pcnext !== 32'h10 || clrbp !== 1'b0) begin
        n_err++; $display("FAIL sat_loop50_%0d: pcnext=%h clrbp=%b want 10 0", i, pcnext, clrbp);
      end
      tick();
    end
    drive(32'h3, 32'h23, 2'b01, 32'h10);
    tick();
    drive(32'h50, 32'h54, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== 32'h23 || clrbp !== 1'b1) begin
      n_err++; $display("FAIL sat_mis: pcnext=%h clrbp=%b want 23 1", pcnext, clrbp);
    end
    tick();
    // saturated at 11, one not-taken leaves it still predicting taken
    drive(32'h3, 32'h23, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== 32'h50 || clrbp !== 1'b0) begin
      n_err++; $display("FAIL sat_hold: pcnext=%h clrbp=%b want 50 0", pcnext, clrbp);
    end
    tick();
    drive(32'h60, 32'h64, 2'b01, 32'h50);
    tick();
    for (int k = 0; k <= ENTRIES; k++) begin
      drive(32'h100 + 32'(k * 16), 32'h104 + 32'(k * 16), 2'b00, 32'h0);
      n_cmp++;
      if (pcnext !== 32'h104 + 32'(k * 16) || clrbp !== 1'b0) begin
        n_err++; $display("FAIL repl_miss%0d: pcnext=%h clrbp=%b", k, pcnext, clrbp);
      end
      tick();
      drive(32'hdead0, 32'hdead4, 2'b01, 32'h400 + 32'(k * 16));
      n_cmp++;
      if (pcnext !== 32'h400 + 32'(k * 16) || clrbp !== 1'b1) begin
        n_err++; $display("FAIL repl_alloc%0d: pcnext=%h clrbp=%b", k, pcnext, clrbp);
      end
      tick();
    end
    drive(32'h3, 32'h23, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== 32'h23 || clrbp !== 1'b0) begin
      n_err++; $display("FAIL repl_slot0_gone: pcnext=%h clrbp=%b want 23 0", pcnext, clrbp);
    end
    tick();
    drive(32'h170, 32'h174, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== 32'h470 || clrbp !== 1'b0) begin
      n_err++; $display("FAIL repl_recent: pcnext=%h clrbp=%b want 470 0", pcnext, clrbp);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] p;
    for (int n = 0; n < 400; n++) begin
      p = 32'h200 + 32'(4 * $urandom_range(0, 11));
      drive(p, p + 32'd4, 2'($urandom_range(0, 3)), 32'h300 + 32'(4 * $urandom_range(0, 7)));
      n_cmp++;
      if (pcnext !== exp_pcnext || clrbp !== exp_clrbp) begin
        n_err++;
        $display("FAIL rand%0d: pc=%h pcnext=%h clrbp=%b want %h %b", n, p, pcnext, clrbp,
                 exp_pcnext, exp_clrbp);
      end
      tick();
    end
`ifdef BHT_PERF_EN
    @(negedge clk);
    n_cmp++;
    if (hit_cnt !== 32'(m_hit_cnt) || mis_cnt !== 32'(m_mis_cnt)) begin
      n_err++;
      $display("FAIL perf_counts: hit=%0d mis=%0d want %0d %0d", hit_cnt, mis_cnt,
               m_hit_cnt, m_mis_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_mispredict();
    drive(32'h904, 32'h908, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== exp_pcnext || clrbp !== exp_clrbp) begin
      n_err++; $display("FAIL rst_pre: pcnext=%h clrbp=%b want %h %b", pcnext, clrbp,
                        exp_pcnext, exp_clrbp);
    end
    tick();
    drive(32'h900, 32'h904, 2'b00, 32'h0);
    tick();
    drive(32'h10, 32'h14, 2'b01, 32'h77);
    n_cmp++;
    if (pcnext !== 32'h77 || clrbp !== 1'b1) begin
      n_err++; $display("FAIL rst_setup_mis: pcnext=%h clrbp=%b want 77 1", pcnext, clrbp);
    end
    reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (pcnext !== 32'h14 || clrbp !== 1'b0) begin
      n_err++; $display("FAIL rst_async: pcnext=%h clrbp=%b want 14 0", pcnext, clrbp);
    end
    tick();
    @(negedge clk);
    reset = 1'b0;
`ifdef BHT_PERF_EN
    n_cmp++;
    if (hit_cnt !== 32'd0 || mis_cnt !== 32'd0) begin
      n_err++; $display("FAIL rst_perf: hit=%0d mis=%0d want 0 0", hit_cnt, mis_cnt);
    end
`endif
    drive(32'h3, 32'h23, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== 32'h23 || clrbp !== 1'b0) begin
      n_err++; $display("FAIL rst_empty3: pcnext=%h clrbp=%b want 23 0", pcnext, clrbp);
    end
    tick();
    drive(32'h170, 32'h174, 2'b00, 32'h0);
    n_cmp++;
    if (pcnext !== 32'h174 || clrbp !== 1'b0) begin
      n_err++; $display("FAIL rst_empty170: pcnext=%h clrbp=%b want 174 0", pcnext, clrbp);
    end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_allocate();
    test_not_taken_mispredict();
    test_saturate_and_replace();
    test_random();
    test_reset_mid_mispredict();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
